// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Count register width, never narrower than one bit so N=1 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full-subtractor cell: computes a - b - borrow_in.
module serial_subtractor_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    always_comb begin
        diff       = a ^ b ^ borrow_in;
        borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b LSB-first, one bit per clock, with
// valid/ready handshakes on the operand and result sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LastCount = CW'(N - 1);

    state_e         r_state;
    state_e         w_state_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   w_a_next;
    logic [N-1:0]   w_b_next;
    logic           r_borrow;
    logic           w_borrow_next;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_next;
    logic           w_d;
    logic           w_bo;

    serial_subtractor_full_subtractor u_cell (
        .a          (r_a[0]),
        .b          (r_b[0]),
        .borrow_in  (r_borrow),
        .diff       (w_d),
        .borrow_out (w_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_borrow <= w_borrow_next;
            r_count  <= w_count_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_a_next      = r_a;
        w_b_next      = r_b;
        w_borrow_next = r_borrow;
        w_count_next  = r_count;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_a_next      = a;
                    w_b_next      = b;
                    w_borrow_next = 1'b0;
                    w_count_next  = '0;
                    w_state_next  = StRun;
                end
            end
            StRun: begin
                // Result bits enter at the MSB so A holds the full difference after N shifts.
                w_a_next         = r_a >> 1;
                w_a_next[N-1]    = w_d;
                w_b_next         = r_b >> 1;
                w_borrow_next    = w_bo;
                w_count_next     = r_count + CW'(1);
                if (r_count == LastCount) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
        diff      = r_a;
        borrow    = r_borrow;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at N=3, N=8 and N=1.
module tb_serial_subtractor;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] diff;
        logic       borrow;
        int         mode;
        string      name;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3_n;
    logic       rst_r_n;
    logic       iv3, ir3, ov3, or3, bo3;
    logic [2:0] a3, b3, d3;

    serial_subtractor #(.N(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .a         (a3),
        .b         (b3),
        .out_valid (ov3),
        .out_ready (or3),
        .diff      (d3),
        .borrow    (bo3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: out_ready high; 1: hold out_ready low 4 extra cycles; 2: toggle in_valid in RUN
    task automatic op3(input logic [2:0] ta, input logic [2:0] tb, input logic [2:0] ed,
                       input logic eb, input int mode, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 32'(ir3), 32'd1);
        iv3 = 1'b1;
        a3  = ta;
        b3  = tb;
        or3 = (mode == 1) ? 1'b0 : 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv3 = 1'b0;
        lat = 0;
        while (!ov3 && lat < 20) begin
            if (mode == 2) begin
                iv3 = ~iv3;
                a3  = 3'($urandom());
                b3  = 3'($urandom());
            end
            @(negedge clk);
            lat++;
        end
        iv3 = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_diff"}, 32'(d3), 32'(ed));
        check({tag, "_borrow"}, 32'(bo3), 32'(eb));
        check({tag, "_in_ready_done"}, 32'(ir3), 32'd0);
        if (mode == 1) begin
            repeat (4) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(ov3), 32'd1);
                check({tag, "_hold_diff"}, 32'(d3), 32'(ed));
                check({tag, "_hold_borrow"}, 32'(bo3), 32'(eb));
                check({tag, "_hold_in_ready"}, 32'(ir3), 32'd0);
            end
            or3 = 1'b1;
        end
        @(negedge clk);
        check({tag, "_back_idle_ready"}, 32'(ir3), 32'd1);
        check({tag, "_back_idle_valid"}, 32'(ov3), 32'd0);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_rand
        localparam int unsigned NN = (gi == 0) ? 8 : 1;
        logic          iv, ir, ov, ordy, bo;
        logic [NN-1:0] ra, rb, rd;
        bit            done_r = 1'b0;

        serial_subtractor #(.N(NN)) u_dut (
            .clk       (clk),
            .rst_n     (rst_r_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (ra),
            .b         (rb),
            .out_valid (ov),
            .out_ready (ordy),
            .diff      (rd),
            .borrow    (bo)
        );

        initial begin
            int          lat;
            int          guard;
            bit          hs;
            logic [NN:0] exp_v;
            iv   = 1'b0;
            ordy = 1'b0;
            ra   = '0;
            rb   = '0;
            @(posedge rst_r_n);
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                guard = 0;
                while (!ir && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 50) begin
                    check("rand_in_ready_timeout", 32'd0, 32'd1);
                    break;
                end
                ra    = NN'($urandom());
                rb    = NN'($urandom());
                exp_v = {1'b0, ra} - {1'b0, rb};
                iv    = 1'b1;
                ordy  = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
                iv  = 1'b0;
                lat = 0;
                while (!ov && lat < 40) begin
                    ordy = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    lat++;
                end
                check("rand_latency", 32'(lat), 32'(NN));
                check("rand_result", 32'({bo, rd}), 32'(exp_v));
                for (int k = 0; k < 10; k++) begin
                    hs = ordy;
                    @(negedge clk);
                    if (hs) break;
                    ordy = (k >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
                end
                check("rand_back_idle", 32'(ir), 32'd1);
            end
            done_r = 1'b1;
        end
    end

    initial begin
        vec_t vecs[9];
        int   k;
        vecs[0] = '{3'd5, 3'd3, 3'd2, 1'b0, 0, "v5m3"};
        vecs[1] = '{3'd3, 3'd5, 3'd6, 1'b1, 0, "v3m5"};
        vecs[2] = '{3'd0, 3'd0, 3'd0, 1'b0, 0, "v0m0"};
        vecs[3] = '{3'd7, 3'd0, 3'd7, 1'b0, 0, "v7m0"};
        vecs[4] = '{3'd0, 3'd7, 3'd1, 1'b1, 0, "v0m7"};
        vecs[5] = '{3'd4, 3'd4, 3'd0, 1'b0, 0, "v4m4"};
        vecs[6] = '{3'd1, 3'd2, 3'd7, 1'b1, 0, "v1m2"};
        vecs[7] = '{3'd6, 3'd1, 3'd5, 1'b0, 1, "bp6m1"};
        vecs[8] = '{3'd2, 3'd6, 3'd4, 1'b1, 2, "tog2m6"};

        rst3_n  = 1'b0;
        rst_r_n = 1'b0;
        iv3     = 1'b0;
        or3     = 1'b0;
        a3      = '0;
        b3      = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(ir3), 32'd1);
        check("reset_out_valid", 32'(ov3), 32'd0);
        check("reset_diff", 32'(d3), 32'd0);
        check("reset_borrow", 32'(bo3), 32'd0);
        rst3_n  = 1'b1;
        rst_r_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            op3(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].mode, vecs[i].name);
        end

        // Asynchronous reset in RUN with count==1, then a fresh operation.
        @(negedge clk);
        iv3 = 1'b1;
        a3  = 3'd1;
        b3  = 3'd6;
        @(posedge clk);
        @(negedge clk);
        iv3 = 1'b0;
        @(posedge clk);
        #2 rst3_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", 32'(ir3), 32'd1);
        check("midrun_rst_out_valid", 32'(ov3), 32'd0);
        check("midrun_rst_diff", 32'(d3), 32'd0);
        check("midrun_rst_borrow", 32'(bo3), 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        op3(3'd6, 3'd2, 3'd4, 1'b0, 0, "post_rst");

        k = 0;
        while (!(g_rand[0].done_r && g_rand[1].done_r) && k < 40000) begin
            @(negedge clk);
            k++;
        end
        check("rand_complete", 32'(g_rand[0].done_r && g_rand[1].done_r), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
